cfo_nco: RTL

CFO_NCO -- requirements
Module: cfo_nco

---
 rtl/cfo_nco_if.sv | 27 ++
 rtl/cfo_nco.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cfo_nco_if.sv
// Quadrature NCO port bundle: frequency word in, sample strobe in, phase/cos/sin out.
// Latency: none (wiring only).
// Backpressure: none; strobes are accepted unconditionally, outputs are valid-qualified.
interface cfo_nco_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int AMP_WIDTH   = 16
);
  logic                          freq_valid_i;
  logic [PHASE_WIDTH-1:0]        freq_word_i;
  logic                          samp_valid_i;
  logic                          nco_valid_o;
  logic [PHASE_WIDTH-1:0]        phase_o;
  logic signed [AMP_WIDTH-1:0]   cos_o;
  logic signed [AMP_WIDTH-1:0]   sin_o;

  // Loop filter / sample source side.
  modport master (
    output freq_valid_i, freq_word_i, samp_valid_i,
    input  nco_valid_o, phase_o, cos_o, sin_o
  );

  // NCO side.
  modport slave (
    input  freq_valid_i, freq_word_i, samp_valid_i,
    output nco_valid_o, phase_o, cos_o, sin_o
  );
endinterface

// File: rtl/cfo_nco.sv
// Carrier-frequency-offset NCO: phase accumulator + quarter-wave LUT giving cos/sin.
// Latency: 3 cycles from samp_valid_i to nco_valid_o, fully pipelined (1 sample/cycle).
// Backpressure: none; outputs hold between strobes. Optional phase dither: CFO_NCO_DITHER_EN.
module cfo_nco #(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int AMP_WIDTH      = 16
) (
  input logic      clk,
  input logic      rst,
  cfo_nco_if.slave nco
);

  localparam int  N     = 1 << LUT_ADDR_WIDTH;
  localparam int  MAG_W = AMP_WIDTH - 1;
  localparam int  LOW_W = PHASE_WIDTH - 2 - LUT_ADDR_WIDTH;
  localparam real PI    = 3.14159265358979323846;

  typedef logic [MAG_W-1:0]          mag_t;
  typedef logic [LUT_ADDR_WIDTH-1:0] addr_t;

  if (LUT_ADDR_WIDTH > PHASE_WIDTH - 4) begin : g_param_check
    $error("cfo_nco: LUT_ADDR_WIDTH must be at most PHASE_WIDTH-4");
  end

  // Quarter-wave table sampled at bin centres, so T[k] and T[N-1-k] are exact
  // mirrors and no entry ever reaches full scale (negation cannot overflow).
  function automatic mag_t lut_entry(input int k);
    real amp;
    real x;
    amp = real'((longint'(1) << (AMP_WIDTH - 1)) - 1);
    x   = amp * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(N));
    return mag_t'($rtoi(x + 0.5));
  endfunction

  function automatic logic signed [AMP_WIDTH-1:0] fold(input mag_t m, input logic neg);
    logic signed [AMP_WIDTH-1:0] v;
    v = $signed({1'b0, m});
    return neg ? -v : v;
  endfunction

  mag_t lut [N];
  for (genvar k = 0; k < N; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  // ---------------- stage 1: accumulator and phase latch ----------------
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] freq_q;
  logic [PHASE_WIDTH-1:0] p1_phase;
  logic                   p1_vld;
  logic [PHASE_WIDTH-1:0] dec_phase;

  // Sample the pre-increment phase; a same-cycle frequency update only affects later steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      freq_q   <= '0;
      p1_phase <= '0;
      p1_vld   <= 1'b0;
    end else begin
      p1_vld <= nco.samp_valid_i;
      if (nco.samp_valid_i) begin
        p1_phase <= acc;
        acc      <= acc + freq_q;
      end
      if (nco.freq_valid_i) begin
        freq_q <= nco.freq_word_i;
      end
    end
  end

`ifdef CFO_NCO_DITHER_EN
  localparam int DW = (LOW_W < 16) ? LOW_W : 16;

  logic [15:0]   lfsr;
  logic [DW-1:0] p1_dith;

  // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, one step per sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= 16'hACE1;
      p1_dith <= '0;
    end else if (nco.samp_valid_i) begin
      p1_dith <= lfsr[DW-1:0];
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Dither only perturbs the LUT addressing; the reported phase stays clean.
  assign dec_phase = p1_phase + PHASE_WIDTH'(p1_dith);
`else
  assign dec_phase = p1_phase;
`endif

  // Bits below the LUT address are truncated away.
  logic unused_low_bits;
  assign unused_low_bits = ^dec_phase[LOW_W-1:0];

  // ---------------- stage 2: quadrant / address decode ----------------
  logic                   p2_vld;
  logic [1:0]             p2_q;
  addr_t                  p2_a;
  logic [PHASE_WIDTH-1:0] p2_phase;

  // Split phase into quadrant and quarter-wave address.
  always_ff @(posedge clk) begin
    if (rst) begin
      p2_vld   <= 1'b0;
      p2_q     <= '0;
      p2_a     <= '0;
      p2_phase <= '0;
    end else begin
      p2_vld <= p1_vld;
      if (p1_vld) begin
        p2_q     <= dec_phase[PHASE_WIDTH-1 -: 2];
        p2_a     <= dec_phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
        p2_phase <= p1_phase;
      end
    end
  end

  // ---------------- stage 3: LUT read and sign fold ----------------
  // Odd quadrants run the quarter wave backwards; sin is negative in q2/q3,
  // cos is negative in q1/q2.
  addr_t sin_idx;
  addr_t cos_idx;
  mag_t  sin_mag;
  mag_t  cos_mag;

  assign sin_idx = p2_q[0] ? ~p2_a : p2_a;
  assign cos_idx = p2_q[0] ? p2_a : ~p2_a;
  assign sin_mag = lut[sin_idx];
  assign cos_mag = lut[cos_idx];

  // Register outputs; they only change on a valid sample and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      nco.nco_valid_o <= 1'b0;
      nco.phase_o     <= '0;
      nco.sin_o       <= '0;
      nco.cos_o       <= '0;
    end else begin
      nco.nco_valid_o <= p2_vld;
      if (p2_vld) begin
        nco.phase_o <= p2_phase;
        nco.sin_o   <= fold(sin_mag, p2_q[1]);
        nco.cos_o   <= fold(cos_mag, p2_q[1] ^ p2_q[0]);
      end
    end
  end

endmodule
